// File: rtl/instr_fetch.sv
// instr_fetch: MIPS instruction fetch stage.
//   Holds the PC, issues word requests to instruction memory (req/gnt, in-order
//   responses) and buffers returned words, paired with their addresses, in a
//   small FIFO presented to decode with a valid/ready handshake. A redirect
//   reloads the PC, empties the FIFO and drops every response still in flight.
// Ports:
//   clk, rst                  clock, async active-high reset
//   imem_req/addr/gnt         request channel (addr word aligned)
//   imem_rvalid/rdata         in-order response channel
//   redirect_valid/pc         jump/branch taken pulse and target
//   id_valid/ready            FIFO head handshake toward decode
//   id_instr/pc/pc_plus4      head instruction, its address, address + 4
//   misaligned                registered pulse for a redirect target with [1:0] != 0
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        misaligned
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_ent_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q;
  logic            pend_q;     // request up and not yet granted
  logic            kill_q;     // the pending request predates a redirect
  logic [31:0]     hold_q;     // address held while a request waits for grant
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr, wr_ptr, aq_rd, aq_wr;
  logic            mis_q;
  fetch_ent_t      fifo [DEPTH];
  logic [31:0]     aq   [DEPTH];

  logic            credit, gnt_fire, rsp_fire, push, pop;
  logic [CW:0]     inflight;
  fetch_ent_t      head;

  // Popping does not return credit in the same cycle.
  assign inflight  = {1'b0, outst_q} + {1'b0, count_q};
  assign credit    = inflight < (CW+1)'(DEPTH);
  assign imem_req  = pend_q | ((state_q == FETCH) & credit);
  assign imem_addr = pend_q ? hold_q : pc_q;
  assign gnt_fire  = imem_req & imem_gnt;
  // A response with nothing outstanding is ignored.
  assign rsp_fire  = imem_rvalid & (outst_q != '0);
  assign push      = rsp_fire & ~redirect_valid & (discard_q == '0);
  assign pop       = id_valid & id_ready;

  assign id_valid    = (count_q != '0);
  assign head        = fifo[rd_ptr];
  assign id_instr    = id_valid ? head.instr : '0;
  assign id_pc       = id_valid ? head.pc    : '0;
  assign id_pc_plus4 = id_pc + 32'd4;
  assign misaligned  = mis_q;

  always_comb begin
    outst_d = outst_q + CW'(gnt_fire) - CW'(rsp_fire);
    count_d = count_q + CW'(push) - CW'(pop);
    // Every in-flight response is stale after a redirect; a killed pending
    // request joins the discard count only once it is actually granted.
    if (redirect_valid)
      discard_d = outst_d;
    else
      discard_d = discard_q - CW'(rsp_fire && (discard_q != '0))
                            + CW'(gnt_fire && kill_q);
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (redirect_valid && (discard_d != '0)) state_d = FLUSH;
      FLUSH:   if (discard_d == '0) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      kill_q    <= 1'b0;
      hold_q    <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
      count_q   <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      aq_rd     <= '0;
      aq_wr     <= '0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      mis_q     <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      pend_q    <= imem_req & ~imem_gnt;
      if (imem_req && !imem_gnt) hold_q <= imem_addr;

      // A killed pending request was issued from the old stream, so its
      // grant must not advance the already-redirected PC.
      if (redirect_valid)       pc_q <= {redirect_pc[31:2], 2'b00};
      else if (gnt_fire && !kill_q) pc_q <= pc_q + 32'd4;

      if (redirect_valid) kill_q <= imem_req & ~imem_gnt;
      else if (gnt_fire)  kill_q <= 1'b0;

      // Address queue tracks every in-flight request, stale or not.
      if (gnt_fire) aq_wr <= aq_wr + AW'(1);
      if (rsp_fire) aq_rd <= aq_rd + AW'(1);

      if (redirect_valid) begin
        count_q <= '0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
      end else begin
        count_q <= count_d;
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Storage needs no reset: the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (gnt_fire) aq[aq_wr] <= imem_addr;
    if (push)     fifo[wr_ptr] <= '{instr: imem_rdata, pc: aq[aq_rd]};
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> (outst_q != '0));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: behavioural in-order memory with
// programmable grant and latency, in-order beat checker on the decode side.
module tb_instr_fetch;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt    = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr, id_pc, id_pc_plus4;
  logic        misaligned;

  int          n_chk = 0, n_bad = 0;
  logic        gnt_en = 1'b1;
  int          lat = 1;
  int          cyc = 0;
  logic        g_flag = 1'b0;
  logic [31:0] g_addr = '0;
  logic [31:0] exp_pc;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];

  instr_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  // Grants are noted mid-cycle and queued just after the next edge, so the
  // latency in force at that negedge applies.
  always @(negedge clk) begin
    g_flag = !rst && imem_req && imem_gnt;
    g_addr = imem_addr;
  end

  always @(posedge clk) begin
    mreq_t m;
    #1;
    imem_gnt = gnt_en;
    if (rst) begin
      mq.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end else begin
      if (g_flag) begin
        m.addr = g_addr;
        m.due  = cyc + lat;
        mq.push_back(m);
      end
      cyc++;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = ~mq[0].addr;
        void'(mq.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Advance to mid-cycle and check any beat decode takes this cycle.
  task automatic step();
    @(negedge clk);
    if (id_valid && id_ready) begin
      chk("beat_pc",    id_pc,       exp_pc);
      chk("beat_instr", id_instr,    ~exp_pc);
      chk("beat_pc4",   id_pc_plus4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic wait_req(input string tag, input logic [31:0] addr);
    for (int i = 0; i < 10 && !imem_req; i++) step();
    chk({tag, "_req"},  imem_req,  1);
    chk({tag, "_addr"}, imem_addr, addr);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"},   imem_req,    0);
    chk({tag, "_addr"},  imem_addr,   RPC);
    chk({tag, "_vld"},   id_valid,    0);
    chk({tag, "_instr"}, id_instr,    0);
    chk({tag, "_pc"},    id_pc,       0);
    chk({tag, "_pc4"},   id_pc_plus4, 32'd4);
    chk({tag, "_mis"},   misaligned,  0);
  endtask

  initial begin
    id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; exp_pc = RPC;
    #1 rst = 1'b1;
    #2 chk_reset_outs("rst");
    repeat (2) @(negedge clk);
    rst = 1'b0; id_ready = 1'b1;

    // reset then stream
    chk("c0_req", imem_req, 0);
    step(); chk("c1_req", imem_req, 1); chk("c1_addr", imem_addr, 32'h100);
    step(); chk("c2_addr", imem_addr, 32'h104);
    step(); chk("c3_vld", id_valid, 1);
    step(); chk("c4_vld", id_valid, 1);
    step(); chk("c5_vld", id_valid, 1);
    repeat (4) step();

    // backpressure
    id_ready = 1'b0;
    repeat (10) step();
    chk("bp_req", imem_req, 0);
    chk("bp_vld", id_valid, 1);
    id_ready = 1'b1;
    repeat (12) step();

    // redirect with two in flight, 3-cycle memory
    lat = 3; gnt_en = 1'b0;
    repeat (8) step();
    gnt_en = 1'b1;
    step();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h400; exp_pc = 32'h400;
    step(); redirect_valid = 1'b0; chk("fl3_req", imem_req, 0);
    step(); chk("fl4_req", imem_req, 0);
    step(); chk("fl5_req", imem_req, 0);
    step(); chk("fl6_req", imem_req, 1); chk("fl6_addr", imem_addr, 32'h400);
    step(); chk("fl7_vld", id_valid, 0);
    step(); chk("fl8_vld", id_valid, 0);
    step(); chk("fl9_vld", id_valid, 0);
    step(); chk("fl10_vld", id_valid, 1); chk("fl10_pc", id_pc, 32'h400);
    lat = 1;
    repeat (6) step();

    // misaligned target
    redirect_valid = 1'b1; redirect_pc = 32'h203; exp_pc = 32'h200;
    chk("mis_pre", misaligned, 0);
    step(); redirect_valid = 1'b0; chk("mis_pulse", misaligned, 1);
    wait_req("mis", 32'h200);
    step(); chk("mis_clr", misaligned, 0);
    repeat (6) step();

    // PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; exp_pc = 32'hFFFF_FFFC;
    step(); redirect_valid = 1'b0;
    wait_req("wrap_a", 32'hFFFF_FFFC);
    step(); chk("wrap_b_req", imem_req, 1); chk("wrap_b_addr", imem_addr, 32'h0);
    repeat (8) step();

    // asynchronous reset between edges
    #2 rst = 1'b1;
    #1 chk_reset_outs("arst");
    lat = 1; gnt_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; exp_pc = RPC;

    // grant stall with redirect during the stall
    chk("st0_req", imem_req, 0);
    step(); chk("st1_req", imem_req, 1); chk("st1_addr", imem_addr, 32'h100);
    step(); chk("st2_addr", imem_addr, 32'h100);
    redirect_valid = 1'b1; redirect_pc = 32'h40; exp_pc = 32'h40;
    step(); redirect_valid = 1'b0;
    chk("st3_req", imem_req, 1); chk("st3_addr", imem_addr, 32'h100);
    step(); chk("st4_addr", imem_addr, 32'h100);
    gnt_en = 1'b1;
    step(); chk("st5_req", imem_req, 1); chk("st5_addr", imem_addr, 32'h100);
    step(); chk("st6_req", imem_req, 1); chk("st6_addr", imem_addr, 32'h40);
    step(); chk("st7_vld", id_valid, 0);
    step(); chk("st8_vld", id_valid, 1); chk("st8_pc", id_pc, 32'h40);
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
